// File: rtl/add_share_sched_pkg.sv
// Shared accelerator constants and the stage-1 payload used by the shared adder scheduler.
package add_share_sched_pkg;

    localparam int DEF_W     = 16;
    localparam int DEF_N_REQ = 4;
    localparam int MAX_N_REQ = 8;
    localparam int ID_MAX_W  = $clog2(MAX_N_REQ);

    localparam int CELL_EXACT  = 0;
    localparam int CELL_APPROX = 1;

    // Operand fields are sized for the accelerator's default datapath width.
    typedef struct packed {
        logic [DEF_W-1:0]    a;
        logic [DEF_W-1:0]    b;
        logic                cin;
        logic [ID_MAX_W-1:0] id;
    } s1_payload_t;

endpackage

// File: rtl/add_share_sched_add_chain.sv
// W-bit ripple chain built from exact or approximate full-adder cells; purely combinational.
module add_chain
    import add_share_sched_pkg::*;
#(
    parameter int W      = DEF_W,
    parameter int APPROX = CELL_APPROX
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W:0]   sum
);

    logic carry;
    logic x;

    // The approximate cell passes A as carry when the operand bits agree, else forwards Cin.
    always_comb begin
        carry = cin;
        x     = 1'b0;
        sum   = '0;
        for (int i = 0; i < W; i++) begin
            x = ~(a[i] ^ b[i]);
            if (APPROX == CELL_APPROX) begin
                sum[i] = x & carry;
                carry  = x ? a[i] : carry;
            end else begin
                sum[i] = a[i] ^ b[i] ^ carry;
                carry  = (a[i] & b[i]) | (a[i] & carry) | (b[i] & carry);
            end
        end
        sum[W] = carry;
    end

endmodule

// File: rtl/add_share_sched.sv
// Round-robin scheduler sharing one adder chain between N_REQ requesters through a
// two-stage pipeline (S1 operand register, S2 result register driving the outputs).
module add_share_sched
    import add_share_sched_pkg::*;
#(
    parameter int N_REQ  = DEF_N_REQ,
    parameter int W      = DEF_W,
    parameter int APPROX = CELL_APPROX,
    parameter int IDW    = $clog2(N_REQ)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N_REQ-1:0]   req_valid,
    output logic [N_REQ-1:0]   req_ready,
    input  logic [N_REQ*W-1:0] req_a,
    input  logic [N_REQ*W-1:0] req_b,
    input  logic [N_REQ-1:0]   req_cin,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [W:0]         res_sum,
    output logic [IDW-1:0]     res_id
);

    // Handshake: a transfer happens on any port whose valid and ready are both high
    // at a rising edge; ready never depends on a transfer on the same port.

    logic [IDW-1:0]   ptr;
    logic [N_REQ-1:0] rot;
    logic [N_REQ-1:0] grant;
    logic [IDW-1:0]   winner;
    logic             found;
    int               off;
    int               sum_idx;

    logic             s1_valid;
    s1_payload_t      s1_q;
    s1_payload_t      s1_d;
    logic             s1_free;
    logic             s2_free;
    logic             accept;
    logic [W:0]       chain_sum;
    logic             unused_id;

    assign s2_free   = !res_valid || res_ready;
    assign s1_free   = !s1_valid || s2_free;
    assign accept    = found && s1_free;
    assign req_ready = grant & {N_REQ{s1_free}};
    assign unused_id = ^s1_q.id;

    // Rotate the valid vector so bit 0 is the requester just after ptr.
    always_comb begin
        rot     = N_REQ'({req_valid, req_valid} >> (int'(ptr) + 1));
        found   = 1'b0;
        off     = 0;
        sum_idx = 0;
        grant   = '0;
        winner  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (!found && rot[i]) begin
                found = 1'b1;
                off   = i;
            end
        end
        sum_idx = int'(ptr) + 1 + off;
        if (sum_idx >= N_REQ) begin
            sum_idx = sum_idx - N_REQ;
        end
        if (found) begin
            grant  = N_REQ'(1) << sum_idx;
            winner = IDW'(sum_idx);
        end
    end

    always_comb begin
        s1_d = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant[i]) begin
                s1_d.a   = DEF_W'(req_a[i*W +: W]);
                s1_d.b   = DEF_W'(req_b[i*W +: W]);
                s1_d.cin = req_cin[i];
            end
        end
        s1_d.id = ID_MAX_W'(winner);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_q     <= '0;
            ptr      <= IDW'(N_REQ - 1);
        end else begin
            if (s1_free) begin
                s1_valid <= accept;
            end
            if (accept) begin
                s1_q <= s1_d;
                ptr  <= winner;
            end
        end
    end

    add_chain #(
        .W      (W),
        .APPROX (APPROX)
    ) u_chain (
        .a   (W'(s1_q.a)),
        .b   (W'(s1_q.b)),
        .cin (s1_q.cin),
        .sum (chain_sum)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_valid <= 1'b0;
            res_sum   <= '0;
            res_id    <= '0;
        end else if (s2_free) begin
            res_valid <= s1_valid;
            if (s1_valid) begin
                res_sum <= chain_sum;
                res_id  <= s1_q.id[IDW-1:0];
            end
        end
    end

endmodule

// File: tb/tb_add_share_sched.sv
// Scoreboard bench driving an exact and an approximate instance with identical stimulus.
module tb_add_share_sched;
    import add_share_sched_pkg::*;

    localparam int N   = 4;
    localparam int W   = 16;
    localparam int IDW = 2;
    localparam int EW  = IDW + W + 1;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [N-1:0]   req_valid;
    logic [N*W-1:0] req_a;
    logic [N*W-1:0] req_b;
    logic [N-1:0]   req_cin;
    logic           res_ready;

    logic [N-1:0]   rdy_e, rdy_a;
    logic           rv_e, rv_a;
    logic [W:0]     sum_e, sum_a;
    logic [IDW-1:0] id_e, id_a;

    add_share_sched #(.N_REQ(N), .W(W), .APPROX(CELL_EXACT)) dut_exact (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(rdy_e),
        .req_a(req_a), .req_b(req_b), .req_cin(req_cin),
        .res_valid(rv_e), .res_ready(res_ready), .res_sum(sum_e), .res_id(id_e)
    );

    add_share_sched #(.N_REQ(N), .W(W), .APPROX(CELL_APPROX)) dut_approx (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(rdy_a),
        .req_a(req_a), .req_b(req_b), .req_cin(req_cin),
        .res_valid(rv_a), .res_ready(res_ready), .res_sum(sum_a), .res_id(id_a)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard state ----------------
    logic [EW-1:0] exp_q_e[$];
    logic [EW-1:0] exp_q_a[$];
    int            checks = 0;
    int            failures = 0;

    logic [N-1:0]  last_acc = '0;
    int            model_ptr = N - 1;
    int            acc_cnt[N];
    int            res_cnt[N];
    int            acc_total = 0;
    int            acc_edge = 0;
    int            last_res_edge = 0;
    logic [W:0]    last_sum_e = '0;
    logic [W:0]    last_sum_a = '0;
    logic [IDW-1:0] last_id_e = '0;
    int            id_log[$];
    int            edge_log[$];
    logic          prev_stall = 1'b0;
    logic [EW-1:0] prev_val = '0;
    int            pick;
    logic [N-1:0]  exp_mask;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    function automatic logic [W:0] ref_add(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic c, input bit approx);
        logic [W:0] r;
        logic       cy;
        logic       xn;
        r  = '0;
        cy = c;
        for (int i = 0; i < W; i++) begin
            xn = (a[i] == b[i]);
            if (approx) begin
                r[i] = xn & cy;
                cy   = xn ? a[i] : cy;
            end else begin
                r[i] = a[i] ^ b[i] ^ cy;
                cy   = (a[i] & b[i]) | (cy & (a[i] | b[i]));
            end
        end
        r[W] = cy;
        return r;
    endfunction

    function automatic int rr_pick(input logic [N-1:0] v, input int p);
        for (int k = 1; k <= N; k++) begin
            if (v[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    // ---------------- monitor: results, then accepts for the upcoming edge ----------------
    always @(negedge clk) begin
        if (!rst_n) begin
            last_acc   = '0;
            prev_stall = 1'b0;
        end else begin
            if (rv_e && res_ready) begin
                if (exp_q_e.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL exact_unexpected_result got=%0h expected=none", {id_e, sum_e});
                end else begin
                    check("exact_result", {id_e, sum_e}, exp_q_e.pop_front());
                end
                last_sum_e    = sum_e;
                last_id_e     = id_e;
                last_res_edge = cyc + 1;
                id_log.push_back(int'(id_e));
                edge_log.push_back(cyc + 1);
                res_cnt[id_e]++;
            end
            if (rv_a && res_ready) begin
                if (exp_q_a.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL approx_unexpected_result got=%0h expected=none", {id_a, sum_a});
                end else begin
                    check("approx_result", {id_a, sum_a}, exp_q_a.pop_front());
                end
                last_sum_a = sum_a;
            end
            if (prev_stall && rv_e) check("stall_hold", {id_e, sum_e}, prev_val);
            prev_stall = rv_e && !res_ready;
            prev_val   = {id_e, sum_e};

            last_acc = rdy_e & req_valid;
            if (rdy_e != '0) begin
                pick     = rr_pick(req_valid, model_ptr);
                exp_mask = (pick >= 0) ? (N'(1) << pick) : '0;
                check("grant", rdy_e, exp_mask);
                for (int i = 0; i < N; i++) begin
                    if (last_acc[i]) begin
                        exp_q_e.push_back({IDW'(i), ref_add(req_a[i*W +: W], req_b[i*W +: W], req_cin[i], 1'b0)});
                        exp_q_a.push_back({IDW'(i), ref_add(req_a[i*W +: W], req_b[i*W +: W], req_cin[i], 1'b1)});
                        acc_cnt[i]++;
                        acc_total++;
                        model_ptr = i;
                    end
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ops(input int i);
        int m;
        m = $urandom_range(0, 7);
        req_a[i*W +: W] = (m == 0) ? 16'h0000 : (m == 1) ? 16'hFFFF : 16'($urandom_range(0, 65535));
        m = $urandom_range(0, 7);
        req_b[i*W +: W] = (m == 0) ? 16'h0000 : (m == 1) ? 16'hFFFF : 16'($urandom_range(0, 65535));
        req_cin[i] = 1'($urandom_range(0, 1));
    endtask

    task automatic refresh(input bit keep);
        for (int i = 0; i < N; i++) begin
            if (last_acc[i]) begin
                set_ops(i);
                req_valid[i] = keep;
            end
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check("reset_valid_drop_exact", rv_e, 0);
        check("reset_valid_drop_approx", rv_a, 0);
        exp_q_e.delete();
        exp_q_a.delete();
        model_ptr = N - 1;
        for (int i = 0; i < N; i++) begin
            acc_cnt[i] = 0;
            res_cnt[i] = 0;
        end
        repeat (2) @(posedge clk);
        #1;
        check("reset_sum", sum_e, 0);
        check("reset_id", id_e, 0);
        check("reset_sum_approx", sum_a, 0);
        if (req_valid == '0) check("reset_ready", rdy_e, 0);
        rst_n = 1'b1;
    endtask

    task automatic issue_one(input int i, input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
        int n;
        req_valid       = '0;
        req_a[i*W +: W] = a;
        req_b[i*W +: W] = b;
        req_cin[i]      = c;
        req_valid[i]    = 1'b1;
        n = 0;
        do begin
            tick();
            n++;
        end while (!last_acc[i] && n < 20);
        if (!last_acc[i]) begin
            checks++; failures++;
            $display("FAIL accept_timeout got=none expected=accept on req %0d", i);
        end
        acc_edge     = cyc;
        req_valid[i] = 1'b0;
    endtask

    task automatic drain();
        int n;
        req_valid = '0;
        res_ready = 1'b1;
        n = 0;
        while ((exp_q_e.size() != 0 || exp_q_a.size() != 0) && n < 100) begin
            tick();
            n++;
        end
        check("drain_empty", exp_q_e.size() + exp_q_a.size(), 0);
        tick();
        check("drain_idle", rv_e, 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog got=running expected=finished");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

    // ---------------- directed and random sequences ----------------
    initial begin
        logic [EW-1:0] held;
        int            guard;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        req_cin   = '0;
        res_ready = 1'b0;
        do_reset();

        // Full carry propagation through the exact chain, two-edge latency.
        res_ready = 1'b1;
        issue_one(2, 16'hFFFF, 16'hFFFF, 1'b1);
        drain();
        check("t1_sum", last_sum_e, 32'h1FFFF);
        check("t1_id", last_id_e, 2);
        check("t1_latency", last_res_edge - acc_edge, 2);

        // Approximate cell corner cases.
        issue_one(1, 16'h0000, 16'h0000, 1'b1);
        drain();
        check("t2a_approx_sum", last_sum_a, 32'h00001);
        issue_one(1, 16'h0001, 16'h0000, 1'b0);
        drain();
        check("t2b_approx_sum", last_sum_a, 32'h00000);
        check("t2b_exact_sum", last_sum_e, 32'h00001);

        // Round-robin order with all requesters continuously valid.
        do_reset();
        res_ready = 1'b1;
        id_log.delete();
        edge_log.delete();
        for (int i = 0; i < N; i++) set_ops(i);
        req_valid = '1;
        repeat (12) begin
            tick();
            refresh(1'b1);
        end
        drain();
        check("t3_result_count_ok", (id_log.size() >= 8) ? 1 : 0, 1);
        if (id_log.size() >= 8) begin
            for (int k = 0; k < 8; k++) check("t3_rr_order", id_log[k], k % N);
            for (int k = 0; k < 7; k++) check("t3_back_to_back", edge_log[k+1] - edge_log[k], 1);
        end

        // Backpressure: fill both stages, hold, then release.
        for (int i = 0; i < N; i++) set_ops(i);
        res_ready = 1'b0;
        req_valid = '1;
        repeat (2) begin
            tick();
            refresh(1'b1);
        end
        check("t4_full_ready", rdy_e, 0);
        check("t4_full_valid", rv_e, 1);
        held = {id_e, sum_e};
        repeat (3) begin
            tick();
            refresh(1'b1);
            check("t4_stall_ready", rdy_e, 0);
            check("t4_stall_hold", {id_e, sum_e}, held);
        end
        res_ready = 1'b1;
        repeat (8) begin
            tick();
            refresh(1'b0);
        end
        drain();

        // Reset with both stages full discards them; requester 0 wins first afterwards.
        for (int i = 0; i < N; i++) set_ops(i);
        res_ready = 1'b0;
        req_valid = '1;
        repeat (2) begin
            tick();
            refresh(1'b1);
        end
        check("t5_full_valid", rv_e, 1);
        do_reset();
        res_ready = 1'b1;
        tick();
        check("t5_first_grant", last_acc, 4'b0001);
        repeat (8) begin
            refresh(1'b0);
            tick();
        end
        drain();

        // Random traffic with random backpressure.
        for (int i = 0; i < N; i++) begin
            acc_cnt[i] = 0;
            res_cnt[i] = 0;
        end
        acc_total = 0;
        guard = 0;
        while (acc_total < 10000 && guard < 60000) begin
            tick();
            guard++;
            res_ready = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < N; i++) begin
                if (last_acc[i] || !req_valid[i]) begin
                    req_valid[i] = ($urandom_range(0, 2) != 0);
                    set_ops(i);
                end
            end
        end
        check("t6_transfers_done", (acc_total >= 10000) ? 1 : 0, 1);
        drain();
        for (int i = 0; i < N; i++) check("t6_per_req_count", res_cnt[i], acc_cnt[i]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
